spi_slave_frame_rx: RTL and testbench
=====================================

Name: spi_slave_frame_rx

Overview:
SPI mode-0 slave receiver for the counter link. It is the receiving end of the 16-bit frames `{2'b00, count[13:0]}` that the counter/SPI-master side sends on each start pulse. Serial SCLK/MOSI/SS_N are oversampled in the clk domain, 16-bit MSB-first frames are assembled, and framing errors are checked. The block presents the received word and a range-checked 14-bit count value to the display logic, and echoes the previously accepted frame on MISO for loopback checking.

Parameters:
DATA_WIDTH, 16, bits per frame; MSB first.
SYNC_STAGES, 2, synchronizer flops on sclk/mosi/ss_n; legal range 2..3.
MAX_VALUE, 9999, largest legal count value; larger values saturate.

Ports:
clk  input  1  system clock; sclk must be at most clk/8.
rst  input  1  reset, asynchronous, active-high.
sclk  input  1  SPI serial clock (CPOL=0, CPHA=0), asynchronous to clk.
mosi  input  1  SPI serial data in.
ss_n  input  1  SPI slave select, active-low.
miso  output  1  SPI serial data out; echo of last accepted rx_data.
rx_data  output  DATA_WIDTH  last complete frame.
rx_valid  output  1  1-clk pulse when rx_data is updated.
rx_error  output  1  1-clk pulse on a short frame or an overrun frame.
value  output  14  count decoded from last complete frame, saturated.
value_valid  output  1  1-clk pulse, coincident with rx_valid.
range_err  output  1  1-clk pulse, coincident with rx_valid, when saturation applied.
busy  output  1  high while a frame is in progress (state RECV or DONE).

Behaviour:
- Reset values:
  - Synchronizer chains: sclk=0, mosi=0, ss_n=1.
  - miso=0, rx_data=0, value=0, all pulses=0, busy=0.
  - bit_cnt=0, shift register=0, state IDLE.
- Edge detection:
  - Edges are detected on the synchronized signals: one register holds the previous value, and an edge fires for one clk cycle.
  - Pin-to-edge-detect latency is SYNC_STAGES+1 clk cycles.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - busy=0.
  - A synchronized ss_n falling edge moves to RECV, clears bit_cnt and the shift register, and loads tx_shift with rx_data.
  - sclk edges in IDLE are ignored.
  - ss_n already low with no falling edge seen (e.g. after reset release mid-frame): remain in IDLE until ss_n goes high and then low again.
- RECV:
  - sclk rising edge: shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_sync}; bit_cnt+1.
  - sclk falling edge: tx_shift shifts left by 1; miso = tx_shift MSB.
  - miso presents the MSB of tx_shift from entry into RECV onward.
  - On the DATA_WIDTH-th rising edge, in the same cycle:
    - rx_data <= assembled word.
    - rx_valid=1 and value_valid=1 for one clk.
    - value <= (word[15:14]!=0 or word[13:0]>MAX_VALUE) ? MAX_VALUE : word[13:0].
    - range_err pulses in the saturating case.
    - State moves to DONE.
  - rx_valid therefore follows the 16th sclk pin rise by SYNC_STAGES+1 clk cycles.
  - ss_n rising edge before 16 bits: rx_error pulses; rx_data/value are unchanged; no rx_valid; state returns to IDLE.
- DONE:
  - miso held at 0.
  - Any further sclk rising edge sets an overrun flag; no data is shifted.
  - ss_n rising edge returns to IDLE; rx_error pulses if the overrun flag is set, and the flag is cleared.
- Simultaneous sclk rising edge and ss_n rising edge in RECV: the ss_n edge wins.
  - Bit not shifted.
  - Treated as a short frame unless bit_cnt had already reached 16.
- rst asserted mid-frame: immediate return to reset values; the partial frame is discarded with no rx_error.
- Back-to-back frames: ss_n high for at least 2 sclk-equivalent periods between frames is required. A new falling edge starts a fresh frame.
- A value of exactly MAX_VALUE passes unsaturated. A value of MAX_VALUE+1 (10000) saturates to 9999 with range_err=1.

Test Plan:
1. Send 16'h0539 (1337), ss_n low→16 sclk→high -> rx_valid and value_valid pulse once; rx_data=16'h0539; value=1337; range_err=0; rx_error=0.
2. Send 16'h2710 (10000), then 16'h270F (9999) -> first frame gives value=9999 with range_err=1; second gives value=9999 with range_err=0.
3. Send 16'h0005, then frame 2 = 16'h0006 while sampling miso on sclk rising edges -> frame 2 miso bits read 16'h0005 MSB first.
4. Send 9 bits then deassert ss_n -> rx_error pulses once; no rx_valid; rx_data and value keep their prior values; busy=0 after.
5. Send 18 sclk pulses in one ss_n window with data 16'h0100 + 2 extra -> rx_valid with rx_data=16'h0100 at bit 16; rx_error pulses at ss_n rise.
6. Assert rst after bit 8, release while ss_n is still low, finish clocking, then run a clean frame 16'h0001 -> no outputs for the broken frame; the clean frame gives value=1.

Source files
------------

// File: rtl/spi_slave_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_frame_rx
// Description : SPI mode-0 slave receiver for the counter link. Oversamples
//               sclk/mosi/ss_n in the clk domain, assembles MSB-first frames,
//               flags short/overrun frames, decodes a saturated 14-bit count
//               and echoes the previously accepted frame on miso.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_frame_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,    // 2..3
  parameter int MAX_VALUE   = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_error,
  output logic [13:0]           value,
  output logic                  value_valid,
  output logic                  range_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [13:0]     MAX_V    = 14'(MAX_VALUE);

  // Synchronizers, edge history and reset-settle tracking
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_n_sync_q, ss_n_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_n_prev_q, ss_n_prev_d;
  logic                   ss_armed_q, ss_armed_d;

  // Frame state
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0]   shift_q, shift_d;     // last bit goes straight to rx_data
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic                    overrun_q, overrun_d;

  // Registered outputs
  logic                    miso_q, miso_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_error_q, rx_error_d;
  logic [13:0]             value_q, value_d;
  logic                    value_valid_q, value_valid_d;
  logic                    range_err_q, range_err_d;
  logic                    busy_q, busy_d;

  // Synchronized views and single-cycle edge strobes
  logic                  sclk_s, mosi_s, ss_n_s;
  logic                  sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_sat;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_s    = ss_n_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_n_s & ~ss_n_prev_q;
  // A falling select only counts once ss_n has genuinely been seen high, so
  // releasing reset in the middle of a frame does not start a bogus frame.
  assign ss_fall   = ~ss_n_s & ss_n_prev_q & ss_armed_q;

  assign word      = {shift_q, mosi_s};
  assign word_sat  = (word[DATA_WIDTH-1:14] != '0) || (word[13:0] > MAX_V);

  // Synchronizer shifting and edge history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_n_sync_d = {ss_n_sync_q[SYNC_STAGES-2:0], ss_n};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sclk_prev_d = sclk_s;
    ss_n_prev_d = ss_n_s;
    // fill_q MSB set means the last sync stage now carries a real pin sample
    ss_armed_d  = ss_armed_q | (fill_q[SYNC_STAGES-1] & ss_n_s);
  end

  // Frame FSM next-state and output computation
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_shift_d    = tx_shift_q;
    overrun_d     = overrun_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    value_d       = value_q;
    rx_valid_d    = 1'b0;
    rx_error_d    = 1'b0;
    value_valid_d = 1'b0;
    range_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d    = ST_RECV;
          bit_cnt_d  = '0;
          shift_d    = '0;
          overrun_d  = 1'b0;
          tx_shift_d = rx_data_q;
          miso_d     = rx_data_q[DATA_WIDTH-1];
        end
      end
      ST_RECV: begin
        // Select release wins over a coincident clock edge: short frame
        if (ss_rise) begin
          rx_error_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d   = word[DATA_WIDTH-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d     = word;
            rx_valid_d    = 1'b1;
            value_valid_d = 1'b1;
            value_d       = word_sat ? MAX_V : word[13:0];
            range_err_d   = word_sat;
            miso_d        = 1'b0;
            state_d       = ST_DONE;
          end
        end else if (sclk_fall) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          rx_error_d = overrun_q;
          overrun_d  = 1'b0;
          state_d    = ST_IDLE;
        end else if (sclk_rise) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      ss_n_sync_q   <= '1;
      fill_q        <= '0;
      sclk_prev_q   <= 1'b0;
      ss_n_prev_q   <= 1'b1;
      ss_armed_q    <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tx_shift_q    <= '0;
      overrun_q     <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_error_q    <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      range_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_n_sync_q   <= ss_n_sync_d;
      fill_q        <= fill_d;
      sclk_prev_q   <= sclk_prev_d;
      ss_n_prev_q   <= ss_n_prev_d;
      ss_armed_q    <= ss_armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      tx_shift_q    <= tx_shift_d;
      overrun_q     <= overrun_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_error_q    <= rx_error_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      range_err_q   <= range_err_d;
      busy_q        <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_error    = rx_error_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign range_err   = range_err_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_frame_rx
// Description : Self-checking bench for spi_slave_frame_rx: directed frames
//               followed by randomized frames against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame_rx;

  localparam int MAXV = 9999;
  localparam int HALF = 8;   // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst, sclk, mosi, ss_n;
  logic        miso, rx_valid, rx_error, value_valid, range_err, busy;
  logic [15:0] rx_data;
  logic [13:0] value;

  spi_slave_frame_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2), .MAX_VALUE(MAXV)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
    .value(value), .value_valid(value_valid), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // pulse counters maintained by the monitor
  int c_valid = 0, c_vv = 0, c_rerr = 0, c_err = 0;

  // frame-level reference model: last accepted word and its decoded value
  logic [15:0] m_data  = 16'h0000;
  int          m_value = 0;

  logic [15:0] mbits;
  logic        busy_mid;

  // Count output pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid)    c_valid++;
    if (value_valid) c_vv++;
    if (range_err)   c_rerr++;
    if (rx_error)    c_err++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one SPI mode-0 frame; optional reset pulse after the 8th bit
  task automatic frame(input logic [15:0] w, input int nbits, input bit do_rst);
    mbits    = 16'h0000;
    busy_mid = 1'b0;
    ss_n = 1'b0;
    clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'($urandom);
      clks(HALF);
      sclk = 1'b1;
      if (i < 16) mbits[15-i] = miso;
      if (i == 2) busy_mid = busy;
      if (do_rst && i == 7) begin
        clks(2); rst = 1'b1; clks(3); rst = 1'b0;
      end
      clks(HALF);
      sclk = 1'b0;
    end
    clks(HALF);
    ss_n = 1'b1;
    clks(5 * HALF);
  endtask

  // Send a frame and compare every observable against the model
  task automatic run_frame(input string tag, input logic [15:0] w, input int nbits);
    int          v0, vv0, re0, e0;
    int          exp_valid, exp_rerr, exp_err;
    logic [15:0] prev, mask;
    v0 = c_valid; vv0 = c_vv; re0 = c_rerr; e0 = c_err;
    prev = m_data;
    frame(w, nbits, 1'b0);
    if (nbits >= 16) begin
      exp_valid = 1;
      exp_rerr  = (int'(w) > MAXV) ? 1 : 0;
      exp_err   = (nbits > 16) ? 1 : 0;
      m_data    = w;
      m_value   = (int'(w) > MAXV) ? MAXV : int'(w);
      mask      = 16'hFFFF;
    end else begin
      exp_valid = 0;
      exp_rerr  = 0;
      exp_err   = 1;
      mask      = 16'hFFFF << (16 - nbits);
    end
    check({tag, ".rx_valid_cnt"}, c_valid - v0, exp_valid);
    check({tag, ".value_valid_cnt"}, c_vv - vv0, exp_valid);
    check({tag, ".range_err_cnt"}, c_rerr - re0, exp_rerr);
    check({tag, ".rx_error_cnt"}, c_err - e0, exp_err);
    check({tag, ".rx_data"}, rx_data, m_data);
    check({tag, ".value"}, value, m_value);
    check({tag, ".busy_after"}, busy, 0);
    if (nbits > 2) check({tag, ".busy_mid"}, busy_mid, 1);
    check({tag, ".miso_echo"}, mbits & mask, prev & mask);
  endtask

  initial begin
    int v0, e0, nb, sel;
    logic [15:0] w;

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    clks(5);
    check("reset.rx_data", rx_data, 0);
    check("reset.value", value, 0);
    check("reset.busy", busy, 0);
    check("reset.miso", miso, 0);
    check("reset.pulses", {rx_valid, value_valid, range_err, rx_error}, 0);
    rst = 1'b0;
    clks(10);

    // nominal frame
    run_frame("t1_1337", 16'h0539, 16);
    // saturation boundary: MAX+1 saturates, MAX passes
    run_frame("t2_10000", 16'h2710, 16);
    run_frame("t2_9999", 16'h270F, 16);
    // miso loopback of previous frame
    run_frame("t3_a", 16'h0005, 16);
    run_frame("t3_b", 16'h0006, 16);
    check("t3.miso_word", mbits, 16'h0005);
    // short frame
    run_frame("t4_short", 16'hABCD, 9);
    // overrun frame
    run_frame("t5_overrun", 16'h0100, 18);

    // reset mid-frame, released with ss_n still low
    v0 = c_valid; e0 = c_err;
    frame(16'h1234, 16, 1'b1);
    m_data = 16'h0000; m_value = 0;
    check("t6.rx_valid_cnt", c_valid - v0, 0);
    check("t6.rx_error_cnt", c_err - e0, 0);
    check("t6.rx_data", rx_data, 0);
    check("t6.value", value, 0);
    check("t6.busy", busy, 0);
    run_frame("t6_clean", 16'h0001, 16);

    // randomized frames
    for (int k = 0; k < 12; k++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       w = 16'($urandom_range(0, 9999));
        1:       w = 16'd9999;
        2:       w = 16'd10000;
        3:       w = 16'($urandom);
        default: w = 16'($urandom_range(9990, 10010));
      endcase
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      nb = 16;
      else if (sel < 8) nb = int'($urandom_range(1, 15));
      else              nb = int'($urandom_range(17, 19));
      run_frame("rand", w, nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
